// File: rtl/axi_lite_master.sv
// axi_lite_master
// ---------------
// AXI4-lite initiator bridging a single-request port onto AXI4-lite read and
// write channels. One transaction is outstanding at a time. A response-wait
// timeout completes the request with an error if the slave never answers.
//
// Ports:
//   ACLK, ARESETn                  clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_write, req_addr,
//   req_wdata, req_wstrb           request payload, captured on accept
//   rsp_valid                      one-cycle completion pulse
//   rsp_rdata, rsp_err             completion data / error, held until next completion
//   AW*, W*, B*, AR*, R*           AXI4-lite master channels
module axi_lite_master #(
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          AXI_DATA_WIDTH = 32,
    parameter int          AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter logic [15:0] TIMEOUT        = 16'd1024
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    // request / response port
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [AXI_DATA_WIDTH-1:0] req_wdata,
    input  logic [AXI_STRB_WIDTH-1:0] req_wstrb,
    output logic                      rsp_valid,
    output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    // write address
    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [AXI_ADDR_WIDTH-1:0] AWADDR,
    output logic [2:0]                AWPROT,
    // write data
    output logic                      WVALID,
    input  logic                      WREADY,
    output logic [AXI_DATA_WIDTH-1:0] WDATA,
    output logic [AXI_STRB_WIDTH-1:0] WSTRB,
    // write response
    input  logic                      BVALID,
    output logic                      BREADY,
    input  logic [1:0]                BRESP,
    // read address
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic [2:0]                ARPROT,
    // read data
    input  logic                      RVALID,
    output logic                      RREADY,
    input  logic [AXI_DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]                RRESP
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_e;

    state_e                    state_q, state_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [AXI_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;

    logic aw_hs, w_hs, timeout_hit;

    // Payload registers feed the channels directly so address/data stay
    // stable for as long as VALID is held.
    assign AWADDR    = addr_q;
    assign ARADDR    = addr_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign AWPROT    = 3'b000;
    assign ARPROT    = 3'b000;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Counter sits at TIMEOUT-1 in the last wait cycle; completion follows
    // one cycle later, i.e. TIMEOUT cycles after entering the response state.
    assign timeout_hit = (TIMEOUT != 16'd0) && (cnt_q == TIMEOUT - 16'd1);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = 1'b0;
        AWVALID     = 1'b0;
        WVALID      = 1'b0;
        BREADY      = 1'b0;
        ARVALID     = 1'b0;
        RREADY      = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    state_d = req_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                AWVALID = !aw_done_q;
                WVALID  = !w_done_q;
                aw_hs   = AWVALID && AWREADY;
                w_hs    = WVALID && WREADY;
                // AW and W may complete in either order or together.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    cnt_d     = '0;
                end else begin
                    aw_done_d = aw_done_q || aw_hs;
                    w_done_d  = w_done_q || w_hs;
                end
            end
            WR_RESP: begin
                BREADY = 1'b1;
                cnt_d  = cnt_q + 16'd1;
                // A response in the timeout cycle takes priority.
                if (BVALID) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = BRESP[1];
                    rsp_rdata_d = '0;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            RD_REQ: begin
                ARVALID = 1'b1;
                if (ARREADY) begin
                    state_d = RD_RESP;
                    cnt_d   = '0;
                end
            end
            RD_RESP: begin
                RREADY = 1'b1;
                cnt_d  = cnt_q + 16'd1;
                if (RVALID) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = RRESP[1];
                    rsp_rdata_d = RDATA;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
